// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the execute stage and the HI/LO multiply-divide unit.
// The execute stage drives the request side and observes busy and the HI/LO registers.
// The unit has no backpressure of its own: a start arriving while busy is high is dropped.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, op, SrcAE, SrcBE,
    input  busy, HI, LO
  );

  modport slave (
    input  start, op, SrcAE, SrcBE,
    output busy, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO, plus zero-latency MTHI/MTLO.
// Latency: MULT_CYCLES or DIV_CYCLES busy cycles; MTHI/MTLO write at the accepting edge.
// Backpressure: busy is high while an operation runs; start during busy is ignored.
// Macro MDU_DIV_EN compiles in the divider and DIV state; without it DIV/DIVU are no-ops.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Both latencies must fit the 4-bit down-counter and be non-zero.
  if (MULT_CYCLES < 1 || MULT_CYCLES > 15 || DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_cfg
    $error("mult_div_unit: MULT_CYCLES and DIV_CYCLES must lie in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1
`ifdef MDU_DIV_EN
    ,
    S_DIV  = 2'd2
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;

  logic        accept;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;

  assign accept = bus.start && !busy_q;

  // Signed products come from sign-extending both operands to 64 bits; the low
  // 64 bits of that product equal the two's-complement signed product.
  assign mul_a = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign mul_b = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod  = mul_a * mul_b;

`ifdef MDU_DIV_EN
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_den;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  // Divide magnitudes, then restore signs: quotient truncates toward zero and
  // the remainder follows the dividend. Working on magnitudes keeps the
  // 0x80000000 / -1 corner well defined (it wraps to 0x80000000).
  assign a_neg   = sgn_q && a_q[31];
  assign b_neg   = sgn_q && b_q[31];
  assign a_mag   = a_neg ? (32'd0 - a_q) : a_q;
  assign b_mag   = b_neg ? (32'd0 - b_q) : b_q;
  assign div_den = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag   = a_mag / div_den;
  assign r_mag   = a_mag % div_den;
  assign quo     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem     = a_neg ? (32'd0 - r_mag) : r_mag;
`endif

  // Next-state: accept in IDLE, count down while busy, commit HI/LO on the last edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              a_d     = bus.SrcAE;
              b_d     = bus.SrcBE;
              sgn_d   = (bus.op == OP_MULT);
              cnt_d   = 4'(MULT_CYCLES);
              busy_d  = 1'b1;
              state_d = S_MUL;
            end
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
              a_d     = bus.SrcAE;
              b_d     = bus.SrcBE;
              sgn_d   = (bus.op == OP_DIV);
              cnt_d   = 4'(DIV_CYCLES);
              busy_d  = 1'b1;
              state_d = S_DIV;
            end
`endif
            OP_MTHI: hi_d = bus.SrcAE;
            OP_MTLO: lo_d = bus.SrcAE;
            // Ops 6/7 (and DIV/DIVU when the divider is absent) do nothing.
            default: ;
          endcase
        end
      end

      S_MUL: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

`ifdef MDU_DIV_EN
      S_DIV: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          // A zero divisor still occupies the full latency but leaves HI/LO alone.
          if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
`endif

      default: begin
        cnt_d   = 4'd0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter, HI/LO and latched operands; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU (legal range 1..15).
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU (legal range 1..15).
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is asynchronous and active-low (reset=0 resets).
REQ-005 Port start, input, 1 bit: execute-stage request valid for the current cycle.
REQ-006 Port op, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-op.
REQ-007 Port SrcAE, input, 32 bits: operand A / dividend / MTHI-MTLO data from the D/E register.
REQ-008 Port SrcBE, input, 32 bits: operand B / divisor from the D/E register.
REQ-009 Port busy, output, 1 bit, registered: operation in progress; hazard logic stalls D/E while busy or start.
REQ-010 Ports HI and LO, output, 32 bits each, registered: architectural HI/LO registers.

Function
REQ-011 The block SHALL be a three-state FSM: IDLE, MUL, DIV, with a 4-bit down-counter.
REQ-012 The block SHALL accept a request only when start=1 and busy=0; any start while busy=1 SHALL be ignored with no state change.
REQ-013 On an accepted MULT/MULTU, the block SHALL latch operands, load the counter with MULT_CYCLES, and enter MUL; busy SHALL rise after that edge.
REQ-014 On an accepted DIV/DIVU, the block SHALL latch operands, load the counter with DIV_CYCLES, and enter DIV; busy SHALL rise after that edge.
REQ-015 The counter SHALL decrement once per cycle; on the edge where it reaches 0, the block SHALL write HI/LO, return to IDLE and drop busy, so busy is high for exactly N cycles.
REQ-016 MULT SHALL form the signed 64-bit product of A and B; MULTU SHALL form the unsigned product; HI gets bits 63:32 and LO gets bits 31:0.
REQ-017 DIV SHALL be signed: LO gets the quotient truncated toward zero, HI gets the remainder with the sign of the dividend; DIVU SHALL be unsigned.
REQ-018 For a divisor of 0, the block SHALL run the full DIV_CYCLES with busy high and leave HI/LO unchanged.
REQ-019 An accepted MTHI/MTLO SHALL write SrcAE to HI/LO at the same edge, with no busy assertion and zero latency.
REQ-020 Ops 6 and 7 SHALL have no effect.
REQ-021 HI/LO SHALL hold their values between writes; intermediate values SHALL never be visible on HI/LO.
REQ-022 Operands latched at acceptance SHALL be used for the whole operation; input changes while busy SHALL be ignored.
REQ-023 A new request presented in the cycle after busy falls SHALL be accepted normally, giving back-to-back operation with no dead cycle.

Reset
REQ-024 While reset=0, asynchronously and irrespective of clk: state=IDLE, counter=0, busy=0, HI=0, LO=0, latched operands=0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no HI/LO write; the first edge after release SHALL behave as IDLE.

Configuration
REQ-026 The macro MDU_DIV_EN SHALL control whether division is compiled in.
REQ-027 With MDU_DIV_EN defined, DIV/DIVU SHALL behave per REQ-014/017/018.
REQ-028 Without MDU_DIV_EN, the divider and the DIV state SHALL be omitted; DIV/DIVU SHALL be treated as no-ops: busy stays 0 and HI/LO are unchanged.

Verification
REQ-029 MULT with A=0xFFFFFFFE, B=0x00000003 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 cycles.
REQ-031 DIV with A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with A=7, B=2 -> LO=3, HI=1.
REQ-032 MULT in progress, then start with MTHI A=0x12345678 at cycle 2 -> ignored, HI = product high word; MTHI after busy falls -> HI=0x12345678 on the next edge.
REQ-033 DIV with B=0 and prior HI=0xA, LO=0xB -> busy 10 cycles, HI=0xA, LO=0xB unchanged.
REQ-034 reset=0 asynchronously at cycle 4 of a DIV -> busy=0, HI=LO=0 immediately; MULT after release completes normally.
